// File: rtl/adder_share_ctrl_if.sv
// Bundle of requester-side and shared-adder signals for adder_share_ctrl.
// The master side is the requesters plus the external adder; the slave side is the controller.
interface adder_share_ctrl_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_result;
  logic [WIDTH-1:0]      res_out;
  logic                  res_carry;
  logic [IDW-1:0]        res_id;
  logic                  res_valid;
  logic                  busy;

  modport master (
    output req, a_in, b_in, add_result,
    input  gnt, add_a, add_b, res_out, res_carry, res_id, res_valid, busy
  );

  modport slave (
    input  req, a_in, b_in, add_result,
    output gnt, add_a, add_b, res_out, res_carry, res_id, res_valid, busy
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one combinational adder among NREQ requesters.
// Two-state flow: IDLE latches the winner's operands, EXEC registers sum and carry.
module adder_share_ctrl #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input logic               clk,
  input logic               rst_n,
  adder_share_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  logic [0:0]       state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   win_q;
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic [WIDTH-1:0] res_out_q;
  logic             res_carry_q;
  logic [IDW-1:0]   res_id_q;
  logic             res_valid_q;

  // Requests rotated so bit 0 corresponds to rr_ptr; first set bit is the winner offset.
  logic [2*NREQ-1:0] req_dbl;
  logic              found;
  logic [IDW-1:0]    off;
  logic [IDW:0]      win_sum;
  logic [IDW-1:0]    win_idx;
  logic [IDW:0]      ptr_sum;
  logic [IDW-1:0]    ptr_nxt;

  assign req_dbl = {bus.req, bus.req} >> rr_ptr_q;

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_dbl[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (win_sum >= (IDW+1)'(NREQ)) begin
      win_sum = win_sum - (IDW+1)'(NREQ);
    end
    win_idx = win_sum[IDW-1:0];
    ptr_sum = {1'b0, win_idx} + (IDW+1)'(1);
    ptr_nxt = (ptr_sum == (IDW+1)'(NREQ)) ? '0 : ptr_sum[IDW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_out_q   <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          res_valid_q <= 1'b0;
          if (found) begin
            add_a_q  <= bus.a_in[int'(win_idx)*WIDTH +: WIDTH];
            add_b_q  <= bus.b_in[int'(win_idx)*WIDTH +: WIDTH];
            gnt_q    <= NREQ'(1) << win_idx;
            win_q    <= win_idx;
            rr_ptr_q <= ptr_nxt;
            state_q  <= EXEC;
          end else begin
            gnt_q <= '0;
          end
        end
        default: begin
          res_out_q   <= bus.add_result;
          // Carry recovered from the wrap: the sum is smaller than an operand iff it overflowed.
          res_carry_q <= (bus.add_result < add_a_q);
          res_id_q    <= win_q;
          res_valid_q <= 1'b1;
          gnt_q       <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.res_out   = res_out_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = (state_q == EXEC);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with an ideal combinational adder on the shared port.
module tb_adder_share_ctrl;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDW   = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  adder_share_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bif ();

  adder_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // The shared adder itself lives outside the controller.
  assign bif.add_result = bif.add_a + bif.add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bif.a_in[i*WIDTH +: WIDTH] = a;
    bif.b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"},   64'(bif.gnt), 0);
    check({tag, ".add_a"}, 64'(bif.add_a), 0);
    check({tag, ".add_b"}, 64'(bif.add_b), 0);
    check({tag, ".res"},   64'(bif.res_out), 0);
    check({tag, ".carry"}, 64'(bif.res_carry), 0);
    check({tag, ".id"},    64'(bif.res_id), 0);
    check({tag, ".valid"}, 64'(bif.res_valid), 0);
    check({tag, ".busy"},  64'(bif.busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single request from requester i, holding until grant; checks the grant and the result.
  task automatic one_op(input string tag, input int i, input logic [31:0] exp_sum,
                        input logic exp_c);
    bif.req = 4'b0001 << i;
    step();
    check({tag, ".gnt"}, 64'(bif.gnt), 64'(4'b0001 << i));
    bif.req = '0;
    step();
    check({tag, ".valid"}, 64'(bif.res_valid), 1);
    check({tag, ".res"},   64'(bif.res_out), 64'(exp_sum));
    check({tag, ".carry"}, 64'(bif.res_carry), 64'(exp_c));
    check({tag, ".id"},    64'(bif.res_id), 64'(i));
  endtask

  logic [31:0] sums2 [4] = '{32'd3, 32'd7, 32'd11, 32'd15};
  logic [3:0]  fair_g [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
  logic [31:0] fair_s [4] = '{32'd42, 32'd300, 32'd42, 32'd300};

  initial begin
    total = 0;
    bad   = 0;
    bif.req  = '0;
    bif.a_in = '0;
    bif.b_in = '0;
    rst_n    = 1'b0;
    step();
    check_zero("reset");
    rst_n = 1'b1;

    // Single request with latency and pulse shape.
    set_ops(0, 32'd10, 32'd1);
    bif.req = 4'b0001;
    step();
    check("t1.gnt",  64'(bif.gnt), 64'h1);
    check("t1.busy", 64'(bif.busy), 1);
    check("t1.v0",   64'(bif.res_valid), 0);
    bif.req = '0;
    step();
    check("t1.gnt0",  64'(bif.gnt), 0);
    check("t1.valid", 64'(bif.res_valid), 1);
    check("t1.res",   64'(bif.res_out), 11);
    check("t1.carry", 64'(bif.res_carry), 0);
    check("t1.id",    64'(bif.res_id), 0);
    check("t1.busy0", 64'(bif.busy), 0);
    step();
    check("t1.vdrop", 64'(bif.res_valid), 0);
    check("t1.hold",  64'(bif.res_out), 11);

    // All four requesters out of reset.
    do_reset();
    set_ops(0, 32'd1, 32'd2);
    set_ops(1, 32'd3, 32'd4);
    set_ops(2, 32'd5, 32'd6);
    set_ops(3, 32'd7, 32'd8);
    bif.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2.gnt", 64'(bif.gnt), 64'(4'b0001 << i));
      check("t2.v0",  64'(bif.res_valid), 0);
      bif.req[i] = 1'b0;
      step();
      check("t2.gnt0",  64'(bif.gnt), 0);
      check("t2.valid", 64'(bif.res_valid), 1);
      check("t2.id",    64'(bif.res_id), 64'(i));
      check("t2.res",   64'(bif.res_out), 64'(sums2[i]));
    end
    step();
    check("t2.idle.gnt", 64'(bif.gnt), 0);
    check("t2.idle.v",   64'(bif.res_valid), 0);

    // Wrap-around carry.
    set_ops(0, 32'hFFFF_FFFF, 32'd1);
    one_op("t3a", 0, 32'd0, 1'b1);
    set_ops(0, 32'h8000_0000, 32'h8000_0000);
    one_op("t3b", 0, 32'd0, 1'b1);
    check("t3.add_a_hold", 64'(bif.add_a), 64'h8000_0000);
    set_ops(3, 32'h7FFF_FFFF, 32'h8000_0000);
    one_op("t3c", 3, 32'hFFFF_FFFF, 1'b0);

    // Fairness between requesters 0 and 2.
    do_reset();
    set_ops(0, 32'd20, 32'd22);
    set_ops(2, 32'd100, 32'd200);
    bif.req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4.gnt", 64'(bif.gnt), 64'(fair_g[i]));
      step();
      check("t4.gnt0", 64'(bif.gnt), 0);
      check("t4.id",   64'(bif.res_id), (fair_g[i] == 4'b0001) ? 0 : 2);
      check("t4.res",  64'(bif.res_out), 64'(fair_s[i]));
    end
    bif.req = '0;
    step();

    // Operand change after grant uses the latched copy.
    set_ops(1, 32'd5, 32'd6);
    bif.req = 4'b0010;
    step();
    check("t5.gnt", 64'(bif.gnt), 64'h2);
    bif.req = '0;
    set_ops(1, 32'd100, 32'd6);
    step();
    check("t5.valid", 64'(bif.res_valid), 1);
    check("t5.res",   64'(bif.res_out), 11);
    check("t5.id",    64'(bif.res_id), 1);

    // Reset during EXEC discards the result and clears rr_ptr.
    set_ops(0, 32'd30, 32'd12);
    set_ops(3, 32'd1, 32'd1);
    bif.req = 4'b0001;
    step();
    check("t6.gnt",  64'(bif.gnt), 64'h1);
    check("t6.busy", 64'(bif.busy), 1);
    bif.req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6.async");
    step();
    check("t6.noval", 64'(bif.res_valid), 0);
    rst_n   = 1'b1;
    bif.req = 4'b1001;
    step();
    check("t6.gnt_rr", 64'(bif.gnt), 64'h1);
    bif.req = '0;
    step();
    check("t6.valid", 64'(bif.res_valid), 1);
    check("t6.res",   64'(bif.res_out), 42);
    check("t6.id",    64'(bif.res_id), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Arbitrating controller that shares one combinational 32-bit adder (`adder32`) among several requesters. Each requester presents two operands with a request line. The controller selects one requester round-robin, drives the winner's latched operands onto the shared adder, and registers the sum and carry. It then returns the result tagged with the requester ID. It sits between the requesting datapath blocks and the single `adder32` instance.

## Interface

Parameters:
- `NREQ`, 4: number of requesters; must be at least 2.
- `WIDTH`, 32: operand and result width; must match the adder width.
- `IDW`, 2: requester ID width, equal to clog2(NREQ).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `req`  input  NREQ  per-requester request level.
- `a_in`  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `b_in`  input  NREQ*WIDTH  operand B, packed the same way as `a_in`.
- `gnt`  output  NREQ  one-hot grant, registered, one-cycle pulse.
- `add_a`  output  WIDTH  registered operand A to the shared adder's `a`.
- `add_b`  output  WIDTH  registered operand B to the shared adder's `b`.
- `add_result`  input  WIDTH  from the shared adder's `result`.
- `res_out`  output  WIDTH  registered sum.
- `res_carry`  output  1  registered unsigned carry-out of the sum.
- `res_id`  output  IDW  index of the requester that owns `res_out`.
- `res_valid`  output  1  one-cycle pulse; `res_out`, `res_carry` and `res_id` are valid while it is high.
- `busy`  output  1  high while in state EXEC.

## Operation

- States:
  - IDLE: sample `req`.
  - EXEC: the adder is evaluating the latched operands.
- IDLE, `req` all zero: remain in IDLE with all pulses low.
- IDLE, any `req` bit set:
  - Select winner w as the first set bit scanning from `rr_ptr` upward, wrapping modulo NREQ.
  - At that edge:
    - `add_a` <= A[w]; `add_b` <= B[w].
    - `gnt` <= one-hot(w); `rr_ptr` <= (w+1) mod NREQ.
    - Move to EXEC.
- EXEC, at the next edge:
  - `res_out` <= `add_result`.
  - `res_carry` <= (`add_result` < `add_a`), compared unsigned.
  - `res_id` <= w; `res_valid` <= 1; `gnt` <= 0.
  - Move to IDLE.
- `req` is ignored while in EXEC.
- Arithmetic is unsigned and wraps modulo 2^WIDTH. The carry is recovered from the wrap and not taken from the adder.
- `add_a` and `add_b` hold their value after EXEC until the next grant.
- `res_out`, `res_carry` and `res_id` hold their last value between `res_valid` pulses.
- Handshake:
  - A requester holds `req` and its operands stable until it sees `gnt`.
  - Operands may change in the cycle after `gnt`; the latched copy is used.
  - To stop, a requester drops `req` in the cycle it sees `gnt`. A `req` still high at the next IDLE sample is a new request.
- Simultaneous requests are resolved only by `rr_ptr`. No requester waits more than NREQ-1 grants.
- Reset asserted at any time, including during EXEC:
  - State returns to IDLE and `rr_ptr` to 0.
  - All outputs are cleared.
  - An in-flight result is discarded and its `res_valid` never asserts.

## Timing

- Reset values: every output is 0 (`gnt`, `add_a`, `add_b`, `res_out`, `res_carry`, `res_id`, `res_valid`, `busy`); `rr_ptr` is 0.
- Latency: `req` sampled at edge E in IDLE; `gnt` and `busy` are high in cycle E..E+1; `res_valid` is high in cycle E+1..E+2.
- Throughput: one operation every 2 cycles under continuous requests.
- Successive `gnt` pulses are at least 2 cycles apart.
- `res_valid` never coincides with `gnt`.
- `add_result` must settle within one clock period; the adder path is combinational.

## Test plan

1. Single request:
   - Stimulus: `req`=4'b0001 with A0=10, B0=1.
   - Response: `gnt`=0001 for one cycle; one cycle later `res_valid`=1, `res_out`=11, `res_carry`=0, `res_id`=0.
2. All four request out of reset, each holding `req` until its grant:
   - Grant order is 0, 1, 2, 3, with pulses 2 cycles apart.
   - Each `res_id` matches its grant; sums are correct for operands (1,2), (3,4), (5,6), (7,8).
3. Wrap-around:
   - Stimulus: A=32'hFFFFFFFF, B=1.
   - Response: `res_out`=0, `res_carry`=1.
   - Repeat with A=32'h80000000, B=32'h80000000: `res_out`=0, `res_carry`=1.
4. Fairness:
   - Stimulus: `req`[0] and `req`[2] held high continuously.
   - Response: grants alternate 0, 2, 0, 2; `gnt`[1] and `gnt`[3] never assert.
5. Operand change after grant:
   - Stimulus: A1=5, B1=6 granted, then A1 changed to 100 in the next cycle.
   - Response: `res_out`=11.
6. Reset mid-operation:
   - Stimulus: `rst_n` pulled low during EXEC.
   - Response: no `res_valid`; all outputs 0 immediately.
   - After release, the next grant to requester 0 comes from `rr_ptr`=0.
